axi_burst_writer: RTL and testbench

// Drains 128-bit words produced by the packer (via the word FIFO) and writes them to DDR as AXI4 INCR write bursts.

---
 rtl/axi_burst_writer.sv | 215 +++++++++++++++++++++
 tb/tb_axi_burst_writer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_writer.sv
// Drains 128-bit words from the word FIFO and writes them to a circular DDR region
// as AXI4 INCR bursts: full bursts when enough words are queued, short bursts on flush.
module axi_burst_writer #(
    parameter int                    WORD_WIDTH   = 128,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    LEVEL_WIDTH  = 5,
    parameter int                    BURST_LEN    = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0000,
    parameter int                    REGION_BYTES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WORD_WIDTH-1:0]   fifo_dout,
    input  logic [LEVEL_WIDTH-1:0]  fifo_level,
    output logic                    fifo_ren,
    input  logic                    flush,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [WORD_WIDTH-1:0]   m_axi_wdata,
    output logic [WORD_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic                    busy,
    output logic                    err,
    output logic [31:0]             beat_count
);

    localparam int                    BYTES      = WORD_WIDTH / 8;
    localparam int                    SIZE_LOG   = $clog2(BYTES);
    localparam logic [ADDR_WIDTH-1:0] REGION_END = BASE_ADDR + ADDR_WIDTH'(REGION_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ONE_A      = ADDR_WIDTH'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] BURST_A    = ADDR_WIDTH'(BURST_LEN);
    localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(BURST_LEN);
    localparam logic [LEVEL_WIDTH-1:0] ZERO_LEVEL = {LEVEL_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_RD   = 3'd2,
        S_LD   = 3'd3,
        S_WB   = 3'd4,
        S_BR   = 3'd5
    } state_t;

    function automatic logic [ADDR_WIDTH-1:0] min_addr(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [ADDR_WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Beats that still fit between the current address and the end of the region.
    function automatic logic [ADDR_WIDTH-1:0] words_to_end(input logic [ADDR_WIDTH-1:0] addr);
        return (REGION_END - addr) >> SIZE_LOG;
    endfunction

    state_t                  state_r;
    state_t                  state_s;
    logic [ADDR_WIDTH-1:0]   awaddr_r;
    logic [7:0]              awlen_r;
    logic [7:0]              beat_r;
    logic [WORD_WIDTH-1:0]   wdata_r;
    logic                    wlast_r;
    logic [31:0]             beat_count_r;
    logic                    err_r;
    logic                    flush_pend_r;

    logic [ADDR_WIDTH-1:0]   room_s;
    logic [ADDR_WIDTH-1:0]   level_s;
    logic [ADDR_WIDTH-1:0]   burst_len_s;
    logic                    start_s;
    logic                    clear_flush_s;
    logic [ADDR_WIDTH-1:0]   sum_addr_s;
    logic [ADDR_WIDTH-1:0]   next_addr_s;

    // IDLE burst decision from the level snapshot, truncated at the region end.
    always_comb begin
        level_s       = ADDR_WIDTH'(fifo_level);
        room_s        = words_to_end(awaddr_r);
        burst_len_s   = min_addr(room_s, BURST_A);
        start_s       = 1'b0;
        clear_flush_s = 1'b0;
        if (state_r == S_IDLE) begin
            if (fifo_level >= FULL_LEVEL) begin
                start_s = 1'b1;
            end else if (flush_pend_r) begin
                if (fifo_level != ZERO_LEVEL) begin
                    start_s       = 1'b1;
                    burst_len_s   = min_addr(room_s, level_s);
                    // Keep the flush pending if the region end cut the burst short.
                    clear_flush_s = (burst_len_s == level_s);
                end else begin
                    clear_flush_s = 1'b1;
                end
            end else begin
                start_s = 1'b0;
            end
        end else begin
            start_s = 1'b0;
        end
    end

    // Next burst start address with wrap back to the region base.
    always_comb begin
        sum_addr_s  = awaddr_r + ((ADDR_WIDTH'(awlen_r) + ONE_A) << SIZE_LOG);
        next_addr_s = (sum_addr_s == REGION_END) ? BASE_ADDR : sum_addr_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  state_s = start_s ? S_AW : S_IDLE;
            S_AW:    state_s = m_axi_awready ? S_RD : S_AW;
            S_RD:    state_s = S_LD;
            S_LD:    state_s = S_WB;
            S_WB: begin
                if (m_axi_wready) begin
                    state_s = wlast_r ? S_BR : S_RD;
                end else begin
                    state_s = S_WB;
                end
            end
            S_BR:    state_s = m_axi_bvalid ? S_IDLE : S_BR;
            default: state_s = S_IDLE;
        endcase
    end

    // Control outputs decoded from the state register.
    always_comb begin
        fifo_ren      = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        busy          = 1'b1;
        case (state_r)
            S_IDLE:  busy          = 1'b0;
            S_AW:    m_axi_awvalid = 1'b1;
            S_RD:    fifo_ren      = 1'b1;
            S_LD:    busy          = 1'b1;
            S_WB:    m_axi_wvalid  = 1'b1;
            S_BR:    m_axi_bready  = 1'b1;
            default: busy          = 1'b0;
        endcase
    end

    // Burst datapath: address, length, beat data, counters and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            awaddr_r     <= BASE_ADDR;
            awlen_r      <= 8'd0;
            beat_r       <= 8'd0;
            wdata_r      <= {WORD_WIDTH{1'b0}};
            wlast_r      <= 1'b0;
            beat_count_r <= 32'd0;
            err_r        <= 1'b0;
            flush_pend_r <= 1'b0;
        end else begin
            flush_pend_r <= (flush_pend_r && !clear_flush_s) || flush;
            case (state_r)
                S_IDLE: begin
                    if (start_s) begin
                        awlen_r <= 8'(burst_len_s - ONE_A);
                        beat_r  <= 8'd0;
                    end
                end
                S_LD: begin
                    wdata_r <= fifo_dout;
                    wlast_r <= (beat_r == awlen_r);
                end
                S_WB: begin
                    if (m_axi_wready) begin
                        beat_count_r <= beat_count_r + 32'd1;
                        beat_r       <= beat_r + 8'd1;
                    end
                end
                S_BR: begin
                    if (m_axi_bvalid) begin
                        err_r    <= err_r | (m_axi_bresp != 2'b00);
                        awaddr_r <= next_addr_s;
                    end
                end
                default: begin
                    beat_r <= beat_r;
                end
            endcase
        end
    end

    assign m_axi_awaddr  = awaddr_r;
    assign m_axi_awlen   = awlen_r;
    assign m_axi_awsize  = 3'(SIZE_LOG);
    assign m_axi_awburst = 2'b01;
    assign m_axi_wdata   = wdata_r;
    assign m_axi_wstrb   = {BYTES{1'b1}};
    assign m_axi_wlast   = wlast_r;
    assign err           = err_r;
    assign beat_count    = beat_count_r;

endmodule

// File: tb/tb_axi_burst_writer.sv
// Bench for axi_burst_writer: FIFO and AXI slave models, a table of burst scenarios
// checked through expected/observed scoreboard queues, plus a mid-burst reset sequence.
module tb_axi_burst_writer;

    localparam int          WW   = 128;
    localparam int          AWD  = 32;
    localparam int          LW   = 5;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int          REG  = 128;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [WW-1:0]   fifo_dout = '0;
    logic [LW-1:0]   fifo_level;
    logic            fifo_ren;
    logic            flush = 1'b0;
    logic [AWD-1:0]  awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready = 1'b0;
    logic [WW-1:0]   wdata;
    logic [WW/8-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready = 1'b0;
    logic [1:0]      bresp = 2'b00;
    logic            bvalid = 1'b0;
    logic            bready;
    logic            busy;
    logic            err;
    logic [31:0]     beat_count;

    axi_burst_writer #(
        .WORD_WIDTH(WW), .ADDR_WIDTH(AWD), .LEVEL_WIDTH(LW), .BURST_LEN(4),
        .BASE_ADDR(BASE), .REGION_BYTES(REG)
    ) dut (
        .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_level(fifo_level),
        .fifo_ren(fifo_ren), .flush(flush),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .busy(busy), .err(err), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nwords;
        bit          do_flush;
        logic [1:0]  resp;
        int          stall;
        bit          has_aw;
        logic [31:0] addr;
        logic [7:0]  len;
        bit          exp_err;
    } vec_t;
    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [WW-1:0] data; logic last; } w_t;

    aw_t            exp_aw[$];
    aw_t            obs_aw[$];
    w_t             exp_w[$];
    w_t             obs_w[$];
    logic [WW-1:0]  pending[$];

    // word FIFO model: data valid one cycle after the read strobe
    logic [WW-1:0]  fifo_mem [0:31];
    logic [4:0]     wr_ptr = 5'd0;
    logic [4:0]     rd_ptr = 5'd0;
    assign fifo_level = wr_ptr - rd_ptr;

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_ren) begin
            fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 5'd1;
        end
    end

    int          stall_at = -1;
    int          stall_cycles = 0;
    logic [1:0]  next_bresp = 2'b00;
    int          w_idx = 0;
    int          ren_cnt = 0;
    int          stable_err = 0;
    int          stall_used = 0;
    int          last_stall_at = -1;
    bit          b_pend = 1'b0;
    bit          b_done = 1'b0;
    bit          prev_hold = 1'b0;
    w_t          prev_w;

    // AXI slave and monitor, acting on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            awready   = 1'b0;
            wready    = 1'b0;
            bvalid    = 1'b0;
            bresp     = 2'b00;
            b_pend    = 1'b0;
            b_done    = 1'b0;
            prev_hold = 1'b0;
            ren_cnt   = 0;
        end else begin
            awready = 1'b1;
            if (stall_at != last_stall_at) begin
                last_stall_at = stall_at;
                stall_used    = 0;
            end
            if (wvalid && w_idx == stall_at && stall_used < stall_cycles) begin
                wready     = 1'b0;
                stall_used = stall_used + 1;
            end else begin
                wready = 1'b1;
            end
            if (b_done) begin
                bvalid = 1'b0;
                b_done = 1'b0;
            end else if (b_pend && !bvalid) begin
                bvalid = 1'b1;
                bresp  = next_bresp;
                b_pend = 1'b0;
            end
            if (prev_hold && (!wvalid || wdata !== prev_w.data || wlast !== prev_w.last))
                stable_err = stable_err + 1;
            prev_hold   = wvalid && !wready;
            prev_w.data = wdata;
            prev_w.last = wlast;
            if (fifo_ren) ren_cnt = ren_cnt + 1;
            if (awvalid && awready) obs_aw.push_back('{awaddr, awlen});
            if (wvalid && wready) begin
                obs_w.push_back('{wdata, wlast});
                w_idx = w_idx + 1;
                if (wlast) b_pend = 1'b1;
            end
            if (bvalid && bready) b_done = 1'b1;
        end
    end

    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_beats = 0;
    int   seq = 0;
    vec_t vecs [0:8];
    vec_t post_vec;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_words(input int n);
        logic [31:0]   s;
        logic [WW-1:0] word;
        for (int i = 0; i < n; i++) begin
            s    = 32'(seq);
            word = {s, ~s, s ^ 32'h5A5A_5A5A, 32'hC0DE_0000 + s};
            seq  = seq + 1;
            fifo_mem[wr_ptr] = word;
            wr_ptr = wr_ptr + 5'd1;
            pending.push_back(word);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        aw_t ea, oa;
        w_t  ew, ow;
        bit  done;
        @(negedge clk);
        stall_at     = (v.stall > 0) ? w_idx + 2 : -1;
        stall_cycles = v.stall;
        next_bresp   = v.resp;
        push_words(v.nwords);
        flush = v.do_flush;
        if (v.has_aw) begin
            exp_aw.push_back('{v.addr, v.len});
            for (int i = 0; i <= int'(v.len); i++)
                exp_w.push_back('{pending.pop_front(), (i == int'(v.len))});
            exp_beats = exp_beats + int'(v.len) + 1;
        end
        @(negedge clk);
        flush = 1'b0;
        done  = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c >= 4 && !busy && obs_aw.size() == exp_aw.size() && obs_w.size() == exp_w.size()) begin
                done = 1'b1;
                break;
            end
        end
        check($sformatf("v%0d_complete", id), done, 1'b1);
        while (exp_aw.size() > 0) begin
            ea = exp_aw.pop_front();
            if (obs_aw.size() == 0) begin
                check($sformatf("v%0d_aw_present", id), 1'b0, 1'b1);
            end else begin
                oa = obs_aw.pop_front();
                check($sformatf("v%0d_awaddr", id), oa.addr, ea.addr);
                check($sformatf("v%0d_awlen", id), oa.len, ea.len);
            end
        end
        check($sformatf("v%0d_no_extra_aw", id), obs_aw.size(), 0);
        while (exp_w.size() > 0) begin
            ew = exp_w.pop_front();
            if (obs_w.size() == 0) begin
                check($sformatf("v%0d_w_present", id), 1'b0, 1'b1);
            end else begin
                ow = obs_w.pop_front();
                check($sformatf("v%0d_wdata", id), ow.data, ew.data);
                check($sformatf("v%0d_wlast", id), ow.last, ew.last);
            end
        end
        check($sformatf("v%0d_no_extra_w", id), obs_w.size(), 0);
        check($sformatf("v%0d_beat_count", id), beat_count, exp_beats);
        check($sformatf("v%0d_ren_count", id), ren_cnt, exp_beats);
        check($sformatf("v%0d_err", id), err, v.exp_err);
        check($sformatf("v%0d_w_stable", id), stable_err, 0);
    endtask

    initial begin
        bit found;
        //          words flush resp stall aw    addr          len    err
        vecs[0] = '{4, 1'b0, 2'b00, 0, 1'b1, 32'h0000_1000, 8'd3, 1'b0};
        vecs[1] = '{4, 1'b0, 2'b00, 5, 1'b1, 32'h0000_1040, 8'd3, 1'b0};
        vecs[2] = '{2, 1'b1, 2'b00, 0, 1'b1, 32'h0000_1000, 8'd1, 1'b0};
        vecs[3] = '{0, 1'b1, 2'b00, 0, 1'b0, 32'h0000_0000, 8'd0, 1'b0};
        vecs[4] = '{4, 1'b0, 2'b00, 0, 1'b1, 32'h0000_1020, 8'd3, 1'b0};
        vecs[5] = '{4, 1'b0, 2'b00, 0, 1'b1, 32'h0000_1060, 8'd1, 1'b0};
        vecs[6] = '{0, 1'b1, 2'b00, 0, 1'b1, 32'h0000_1000, 8'd1, 1'b0};
        vecs[7] = '{4, 1'b0, 2'b10, 0, 1'b1, 32'h0000_1020, 8'd3, 1'b1};
        vecs[8] = '{4, 1'b0, 2'b00, 0, 1'b1, 32'h0000_1060, 8'd1, 1'b1};
        post_vec = '{4, 1'b0, 2'b00, 0, 1'b1, 32'h0000_1000, 8'd3, 1'b0};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_wlast", wlast, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_fifo_ren", fifo_ren, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_awaddr", awaddr, BASE);
        check("rst_awlen", awlen, 8'd0);
        check("rst_wdata", wdata, 128'd0);
        check("rst_beat_count", beat_count, 32'd0);
        check("awsize", awsize, 3'd4);
        check("awburst", awburst, 2'b01);
        check("wstrb", wstrb, 16'hFFFF);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // reset while a beat is held on the W channel
        @(negedge clk);
        stall_at     = w_idx;
        stall_cycles = 1000;
        push_words(4);
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (wvalid) begin
                found = 1'b1;
                break;
            end
        end
        check("midrst_wvalid_seen", found, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_wvalid", wvalid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_awvalid", awvalid, 1'b0);
        check("midrst_awaddr", awaddr, BASE);
        check("midrst_beat_count", beat_count, 32'd0);
        check("midrst_err", err, 1'b0);
        @(negedge clk);
        stall_at     = -1;
        stall_cycles = 0;
        pending.delete();
        exp_aw.delete();
        exp_w.delete();
        obs_aw.delete();
        obs_w.delete();
        exp_beats = 0;
        rst = 1'b0;

        run_vec(post_vec, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
